// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display blocks:
// segment encodings (gfedcba, active-high), blank select pattern and scan FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7C;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;

  // Active-low selects: all ones means no digit is being driven.
  localparam logic [7:0] SEL_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_pat_dec.sv
// Seven-segment pattern to BCD decoder; valid is low for any pattern outside
// the encoder table.
module seg_pat_dec (
  input  logic [6:0] pat,
  output logic [3:0] bcd,
  output logic       valid
);
  import seg_pkg::*;

  always_comb begin
    bcd   = '0;
    valid = 1'b1;
    case (pat)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Recovers digit values from a multiplexed seven-segment display bus by
// waiting for the bus to settle and capturing once per stable dwell.
module seg_scan_rx #(
  parameter int NUM_DIG    = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [6:0]           SEG_C,
  input  logic [NUM_DIG-1:0]   SEG_SEL,
  output logic [4*NUM_DIG-1:0] DIGITS,
  output logic [NUM_DIG-1:0]   DIG_VALID,
  output logic                 FRAME_DONE,
  output logic                 SEG_ERR,
  output logic [2:0]           ERR_DIG
);
  import seg_pkg::*;

  localparam int CW = $clog2(STABLE_CYC) + 1;
  // Change detection costs one cycle after the synchronizers, so the capture
  // compare point sits two below STABLE_CYC to land at 2+STABLE_CYC overall.
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYC - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [NUM_DIG-1:0] SEL_IDLE = SEL_BLANK[NUM_DIG-1:0];

  logic [NUM_DIG-1:0] sel_meta, sel_sync, sel_last;
  logic [6:0]         c_meta, c_sync, c_last;
  logic               changed;
  logic               sel_ok;
  logic [2:0]         sel_idx;
  logic [3:0]         dec_bcd;
  logic               dec_ok;
  logic               capture;
  logic               wrap;

  scan_state_t        state;
  logic [CW-1:0]      stab_cnt;
  logic [2:0]         prev_idx;
  logic               prev_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_meta <= SEL_IDLE;
      sel_sync <= SEL_IDLE;
      sel_last <= SEL_IDLE;
      c_meta   <= '0;
      c_sync   <= '0;
      c_last   <= '0;
    end else begin
      sel_meta <= SEG_SEL;
      sel_sync <= sel_meta;
      sel_last <= sel_sync;
      c_meta   <= SEG_C;
      c_sync   <= c_meta;
      c_last   <= c_sync;
    end
  end

  assign changed = (sel_sync != sel_last) || (c_sync != c_last);

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      if (!sel_sync[i]) sel_idx = 3'(i);
    end
  end

  // Blank and multi-select buses still advance the FSM but never capture.
  assign sel_ok  = $onehot(~sel_sync);
  assign capture = (state == ST_SETTLE) && !changed && (stab_cnt == CNT_CAP) && sel_ok;
  assign wrap    = prev_ok && (sel_idx <= prev_idx);

  seg_pat_dec u_dec (
    .pat   (c_sync),
    .bcd   (dec_bcd),
    .valid (dec_ok)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      stab_cnt   <= '0;
      prev_idx   <= '0;
      prev_ok    <= 1'b0;
      DIGITS     <= '0;
      DIG_VALID  <= '0;
      FRAME_DONE <= 1'b0;
      SEG_ERR    <= 1'b0;
      ERR_DIG    <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      SEG_ERR    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (changed) begin
            state    <= ST_SETTLE;
            stab_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (changed) begin
            stab_cnt <= '0;
          end else if (stab_cnt == CNT_CAP) begin
            state    <= ST_HELD;
            stab_cnt <= stab_cnt + 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (changed) begin
            state    <= ST_SETTLE;
            stab_cnt <= '0;
          end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          stab_cnt <= '0;
        end
      endcase

      if (capture) begin
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
          if (sel_idx == 3'(i)) begin
            if (dec_ok) begin
              DIGITS[4*i +: 4] <= dec_bcd;
              DIG_VALID[i]     <= 1'b1;
            end else begin
              DIG_VALID[i]     <= 1'b0;
            end
          end
        end
        if (!dec_ok) begin
          SEG_ERR <= 1'b1;
          ERR_DIG <= sel_idx;
        end
        FRAME_DONE <= wrap;
        prev_idx   <= sel_idx;
        prev_ok    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: stimulus runs are scored by a run-length
// reference model; a monitor pops expected capture events as outputs move.
module tb_seg_scan_rx;

  localparam int NUM_DIG    = 8;
  localparam int STABLE_CYC = 4;

  logic        CLK;
  logic        RESET;
  logic [6:0]  SEG_C;
  logic [7:0]  SEG_SEL;
  logic [31:0] DIGITS;
  logic [7:0]  DIG_VALID;
  logic        FRAME_DONE;
  logic        SEG_ERR;
  logic [2:0]  ERR_DIG;

  seg_scan_rx #(.NUM_DIG(NUM_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SEG_C      (SEG_C),
    .SEG_SEL    (SEG_SEL),
    .DIGITS     (DIGITS),
    .DIG_VALID  (DIG_VALID),
    .FRAME_DONE (FRAME_DONE),
    .SEG_ERR    (SEG_ERR),
    .ERR_DIG    (ERR_DIG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int unsigned cyc;
    logic [31:0] digits;
    logic [7:0]  valid;
    logic        fd;
    logic        err;
    logic [2:0]  errdig;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  // Reference model state: what the display should currently show.
  logic [3:0] m_dig [8];
  logic [7:0] m_val;
  logic [2:0] m_errdig;
  int         m_prev;
  bit         m_have;

  // Current input run: value, start cycle, length, and whether it is spent.
  logic [7:0]  run_sel;
  logic [6:0]  run_c;
  int unsigned run_start;
  int unsigned run_len;
  bit          run_cap;

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pack_dig();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = m_dig[i];
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_val    = '0;
    m_errdig = '0;
    m_prev   = 0;
    m_have   = 0;
  endtask

  task automatic model_capture(input logic [7:0] sel, input logic [6:0] c, input int unsigned t);
    int          zeros = 0;
    int          idx   = 0;
    int          v     = -1;
    logic [31:0] old_d;
    logic [7:0]  old_v;
    bit          fd;
    bit          err;
    exp_t        e;
    for (int i = 0; i < 8; i++) if (!sel[i]) begin zeros++; idx = i; end
    if (zeros != 1) return;
    for (int k = 0; k < 10; k++) if (codes[k] == c) v = k;
    old_d = pack_dig();
    old_v = m_val;
    err   = (v < 0);
    if (!err) begin
      m_dig[idx] = 4'(v);
      m_val[idx] = 1'b1;
    end else begin
      m_val[idx] = 1'b0;
      m_errdig   = 3'(idx);
    end
    fd     = m_have && (idx <= m_prev);
    m_prev = idx;
    m_have = 1;
    if (fd || err || pack_dig() != old_d || m_val != old_v) begin
      e.cyc    = t;
      e.digits = pack_dig();
      e.valid  = m_val;
      e.fd     = fd;
      e.err    = err;
      e.errdig = m_errdig;
      q.push_back(e);
    end
  endtask

  // Drive a bus value for dur cycles; a run of STABLE_CYC or more identical
  // samples that differs from the previous run produces one capture.
  task automatic apply(input logic [7:0] sel, input logic [6:0] c, input int unsigned dur);
    if (sel != run_sel || c != run_c) begin
      run_sel   = sel;
      run_c     = c;
      run_start = cyc;
      run_len   = 0;
      run_cap   = 0;
    end
    SEG_SEL = sel;
    SEG_C   = c;
    if (!run_cap && run_len + dur >= STABLE_CYC) begin
      model_capture(run_sel, run_c, run_start + 2 + STABLE_CYC);
      run_cap = 1;
    end
    run_len += dur;
    repeat (dur) @(negedge CLK);
  endtask

  task automatic idle(input int unsigned n);
    apply(run_sel, run_c, n);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() != 0; k++) idle(1);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL drain_timeout: event due at cycle %0d never seen, expected digits %0h", e.cyc, e.digits);
    end
  endtask

  // Reset discards captures that had not yet happened in the DUT.
  task automatic do_reset();
    exp_t keep[$];
    foreach (q[i]) begin
      if (q[i].cyc <= cyc) begin
        n_chk++;
        $display("FAIL missed_event: event due at cycle %0d not seen before reset", q[i].cyc);
      end
    end
    q = keep;
    RESET = 1'b1;
    model_clear();
    repeat (3) @(negedge CLK);
    chk("rst_digits", DIGITS, 32'h0);
    chk("rst_valid", {24'h0, DIG_VALID}, 32'h0);
    chk("rst_frame_done", {31'h0, FRAME_DONE}, 32'h0);
    chk("rst_seg_err", {31'h0, SEG_ERR}, 32'h0);
    chk("rst_err_dig", {29'h0, ERR_DIG}, 32'h0);
    RESET     = 1'b0;
    run_start = cyc;
    run_len   = 0;
    run_cap   = (run_sel == 8'hFF && run_c == 7'h00);
  endtask

  // Monitor: any output movement or pulse is one capture event.
  initial begin
    logic [31:0] pd;
    logic [7:0]  pv;
    logic [2:0]  pe;
    exp_t        e;
    pd = '0; pv = '0; pe = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET && (DIGITS !== pd || DIG_VALID !== pv || ERR_DIG !== pe ||
                     FRAME_DONE !== 1'b0 || SEG_ERR !== 1'b0)) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: digits %0h valid %0h fd %0b err %0b err_dig %0d, expected no change (cycle %0d)",
                   DIGITS, DIG_VALID, FRAME_DONE, SEG_ERR, ERR_DIG, cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("digits", DIGITS, e.digits);
          chk("dig_valid", {24'h0, DIG_VALID}, {24'h0, e.valid});
          chk("frame_done", {31'h0, FRAME_DONE}, {31'h0, e.fd});
          chk("seg_err", {31'h0, SEG_ERR}, {31'h0, e.err});
          chk("err_dig", {29'h0, ERR_DIG}, {29'h0, e.errdig});
        end
      end
      pd = DIGITS;
      pv = DIG_VALID;
      pe = ERR_DIG;
    end
  end

  initial begin
    logic [7:0] one;
    logic [7:0] sel;
    logic [6:0] c;
    int unsigned r;
    one     = 8'h01;
    RESET   = 1'b1;
    SEG_SEL = 8'hFF;
    SEG_C   = 7'h00;
    run_sel = 8'hFF;
    run_c   = 7'h00;
    run_start = 0;
    run_len = 0;
    run_cap = 1;
    model_clear();
    repeat (2) @(negedge CLK);
    do_reset();

    // Single digit held long: one capture, 2+STABLE_CYC after the change.
    apply(8'hFE, 7'h5B, 10);

    // Toggling faster than the settle window, then held.
    for (int i = 0; i < 3; i++) begin
      apply(8'hFD, 7'h3F, 2);
      apply(8'hFD, 7'h06, 2);
    end
    apply(8'hFD, 7'h3F, 2);
    apply(8'hFD, 7'h06, 10);
    drain();

    // Scan wrap-around from a fresh reset.
    do_reset();
    apply(8'hFE, 7'h67, 8);
    apply(8'hFD, 7'h7C, 8);
    apply(8'hFE, 7'h3F, 8);

    // Valid slot 2, then an undecodable pattern on slot 2 (also a wrap).
    apply(8'hFB, 7'h66, 8);
    apply(8'hFB, 7'h7D, 8);

    // Blank and multi-select buses.
    apply(8'hFF, 7'h3F, 8);
    apply(8'hFC, 7'h06, 8);
    apply(8'hFC, 7'h5B, 8);
    drain();

    // Reset in the middle of a settle window.
    apply(8'hFE, 7'h4F, 4);
    do_reset();
    idle(10);
    drain();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      sel = 8'hFF;
      else if (r == 1) sel = 8'($urandom);
      else             sel = ~(one << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) c = 7'($urandom);
      else                           c = codes[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) begin
        sel = run_sel;
        c   = run_c;
      end
      apply(sel, c, $urandom_range(1, 8));
    end
    drain();
    idle(20);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
